// File: rtl/led_pio_ctrl.sv
// led_pio_ctrl: Avalon-MM LED PIO with atomic set/clear/toggle, per-bit blink and global PWM
module led_pio_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic [3:0]       avs_byteenable,
    output logic [31:0]      avs_readdata,
    output logic [WIDTH-1:0] leds_export
);
    localparam logic [7:0] WIDTH_B = 8'(WIDTH);
    logic [WIDTH-1:0] data_q, data_d, mask_q, mask_d, leds_q, leds_d;
    logic [DIV_W-1:0] div_q, div_d, presc_q, presc_d;
    logic [7:0]       duty_q, duty_d, pwm_cnt_q, pwm_cnt_d;
    logic             phase_q, phase_d, pwm_on, div_wr;
    logic [31:0]      rdata_q, rdata_d, be_mask, wd, rd_mux;

    // Register writes: disabled byte lanes keep their bits (or act as zero for SET/CLR/TOG)
    always_comb begin
        be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}}, {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
        wd      = avs_writedata & be_mask;
        data_d  = data_q;
        mask_d  = mask_q;
        div_d   = div_q;
        duty_d  = duty_q;
        if (avs_write) begin
            case (avs_address)
                3'd0: data_d = (data_q & ~be_mask[WIDTH-1:0]) | wd[WIDTH-1:0];
                3'd1: data_d = data_q | wd[WIDTH-1:0];
                3'd2: data_d = data_q & ~wd[WIDTH-1:0];
                3'd3: data_d = data_q ^ wd[WIDTH-1:0];
                3'd4: mask_d = (mask_q & ~be_mask[WIDTH-1:0]) | wd[WIDTH-1:0];
                3'd5: div_d  = (div_q & ~be_mask[DIV_W-1:0]) | wd[DIV_W-1:0];
                3'd6: duty_d = (duty_q & ~be_mask[7:0]) | wd[7:0];
                default: ;
            endcase
        end
    end

    // Blink prescaler, PWM counter and LED output term
    always_comb begin
        div_wr    = avs_write && (avs_address == 3'd5);
        presc_d   = div_wr ? div_d : (div_q == '0) ? '0 : (presc_q == '0) ? div_q : presc_q - DIV_W'(1);
        phase_d   = div_wr ? 1'b0 : (div_q == '0) ? 1'b0 : (presc_q == '0) ? ~phase_q : phase_q;
        pwm_cnt_d = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
        pwm_on    = pwm_cnt_q < duty_q;
        leds_d    = (data_q ^ (mask_q & {WIDTH{phase_q}})) & {WIDTH{pwm_on}};
    end

    // Read mux returns pre-write state; readdata holds when no read is issued
    always_comb begin
        case (avs_address)
            3'd0:    rd_mux = 32'(data_q);
            3'd4:    rd_mux = 32'(mask_q);
            3'd5:    rd_mux = 32'(div_q);
            3'd6:    rd_mux = 32'(duty_q);
            3'd7:    rd_mux = {WIDTH_B, 15'd0, phase_q, pwm_cnt_q};
            default: rd_mux = '0;
        endcase
        rdata_d = avs_read ? rd_mux : rdata_q;
    end

    // State registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            data_q    <= RESET_VALUE;
            mask_q    <= '0;
            div_q     <= '0;
            duty_q    <= 8'd255;
            presc_q   <= '0;
            phase_q   <= 1'b0;
            pwm_cnt_q <= '0;
            rdata_q   <= '0;
            leds_q    <= RESET_VALUE;
        end else begin
            data_q    <= data_d;
            mask_q    <= mask_d;
            div_q     <= div_d;
            duty_q    <= duty_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            rdata_q   <= rdata_d;
            leds_q    <= leds_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign leds_export  = leds_q;
endmodule

// File: tb/tb_led_pio_ctrl.sv
// tb_led_pio_ctrl: self-checking bench for led_pio_ctrl with a read scoreboard
module tb_led_pio_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [31:0] avs_readdata;
    logic [7:0]  leds_export;
    logic [31:0] exp_q[$];
    logic [31:0] msk_q[$];
    int          errors = 0;
    int          checks = 0;

    led_pio_ctrl #(.WIDTH(8), .DIV_W(24), .RESET_VALUE(8'hA5)) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata),
        .leds_export(leds_export)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        @(negedge clk);
        avs_write      = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input logic [31:0] m, input string nm);
        logic [31:0] ee, mm;
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(e);
        msk_q.push_back(m);
        @(negedge clk);
        avs_read = 1'b0;
        ee = exp_q.pop_front();
        mm = msk_q.pop_front();
        checks++;
        if ((avs_readdata & mm) !== ee) begin
            errors++;
            $display("FAIL %s: readdata=%h expected %h", nm, avs_readdata & mm, ee);
        end
    endtask

    task automatic chk_leds(input logic [7:0] e, input string nm);
        checks++;
        if (leds_export !== e) begin
            errors++;
            $display("FAIL %s: leds=%h expected %h", nm, leds_export, e);
        end
    endtask

    task automatic test_reset;
        int bad;
        bad = 0;
        checks++;
        if (avs_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: readdata=%h expected 00000000", avs_readdata);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (leds_export !== 8'hA5) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_leds: %0d cycles off, expected 0 (leds=%h, want a5)", bad, leds_export);
        end
        rd(3'd7, 32'h0800_0000, 32'hFFFF_FF00, "reset_status");
        rd(3'd0, 32'hA5, 32'hFFFF_FFFF, "reset_data");
        rd(3'd4, 32'h0, 32'hFFFF_FFFF, "reset_mask");
        rd(3'd5, 32'h0, 32'hFFFF_FFFF, "reset_div");
        rd(3'd6, 32'hFF, 32'hFFFF_FFFF, "reset_duty");
        @(negedge clk);
        checks++;
        if (avs_readdata !== 32'hFF) begin
            errors++;
            $display("FAIL rdata_hold: readdata=%h expected 000000ff", avs_readdata);
        end
    endtask

    task automatic test_atomic;
        logic [31:0] a_addr[4] = '{32'd0, 32'd1, 32'd2, 32'd3};
        logic [31:0] a_wd[4]   = '{32'h0F, 32'h30, 32'h01, 32'hFF};
        logic [7:0]  a_exp[4]  = '{8'h0F, 8'h3F, 8'h3E, 8'hC1};
        logic [7:0]  prev;
        prev = leds_export;
        for (int i = 0; i < 4; i++) begin
            wr(a_addr[i][2:0], a_wd[i], 4'hF);
            chk_leds(prev, "atomic_latency");
            @(negedge clk);
            chk_leds(a_exp[i], "atomic_leds");
            rd(3'd0, 32'(a_exp[i]), 32'hFFFF_FFFF, "atomic_data");
            prev = a_exp[i];
        end
        rd(3'd1, 32'h0, 32'hFFFF_FFFF, "set_reads0");
        rd(3'd2, 32'h0, 32'hFFFF_FFFF, "clr_reads0");
        rd(3'd3, 32'h0, 32'hFFFF_FFFF, "tog_reads0");
    endtask

    task automatic test_byteenable;
        wr(3'd0, 32'h1234_5678, 4'b0001);
        rd(3'd0, 32'h78, 32'hFFFF_FFFF, "be_data");
        wr(3'd1, 32'h0000_FF00, 4'b0000);
        rd(3'd0, 32'h78, 32'hFFFF_FFFF, "be_set_none");
        wr(3'd2, 32'h0000_00FF, 4'b1110);
        rd(3'd0, 32'h78, 32'hFFFF_FFFF, "be_clr_off");
        wr(3'd3, 32'hFFFF_FF00, 4'b1111);
        rd(3'd0, 32'h78, 32'hFFFF_FFFF, "tog_above_width");
        wr(3'd5, 32'hFFFF_FFFF, 4'b1111);
        rd(3'd5, 32'h00FF_FFFF, 32'hFFFF_FFFF, "div_width");
        wr(3'd7, 32'hFFFF_FFFF, 4'b1111);
        rd(3'd7, 32'h0800_0000, 32'hFFFF_FE00, "status_ro");
    endtask

    task automatic test_blink;
        wr(3'd4, 32'h03, 4'hF);
        wr(3'd0, 32'h00, 4'hF);
        wr(3'd5, 32'h03, 4'hF);
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk);
            chk_leds((((t - 1) / 4) % 2 == 1) ? 8'h03 : 8'h00, "blink_phase");
        end
        wr(3'd5, 32'h0, 4'hF);
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            chk_leds(8'h00, "blink_off");
        end
        rd(3'd7, 32'h0800_0000, 32'hFFFF_FF00, "blink_off_status");
    endtask

    task automatic test_back_to_back;
        logic [31:0] ee;
        wr(3'd0, 32'h00, 4'hF);
        @(negedge clk);
        avs_address    = 3'd0;
        avs_writedata  = 32'h55;
        avs_byteenable = 4'hF;
        avs_write      = 1'b1;
        avs_read       = 1'b1;
        exp_q.push_back(32'h00);
        @(negedge clk);
        avs_read      = 1'b0;
        avs_address   = 3'd1;
        avs_writedata = 32'h80;
        ee = exp_q.pop_front();
        checks++;
        if (avs_readdata !== ee) begin
            errors++;
            $display("FAIL rw_same_cycle: readdata=%h expected %h", avs_readdata, ee);
        end
        @(negedge clk);
        avs_write = 1'b0;
        chk_leds(8'h55, "b2b_first");
        @(negedge clk);
        chk_leds(8'hD5, "b2b_second");
        rd(3'd0, 32'hD5, 32'hFFFF_FFFF, "b2b_data");
    endtask

    task automatic test_pwm;
        int on_cnt, bad, run, max_run;
        wr(3'd4, 32'h00, 4'hF);
        wr(3'd0, 32'hFF, 4'hF);
        wr(3'd6, 32'h1FF, 4'b0011);
        rd(3'd6, 32'hFF, 32'hFFFF_FFFF, "duty_width");
        wr(3'd6, 32'd64, 4'hF);
        rd(3'd6, 32'd64, 32'hFFFF_FFFF, "duty_rb");
        on_cnt = 0; bad = 0; run = 0; max_run = 0;
        for (int i = 0; i < 510; i++) begin
            @(negedge clk);
            if (leds_export === 8'hFF) begin
                on_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
                if (leds_export !== 8'h00) bad++;
            end
        end
        checks++;
        if (on_cnt != 128 || bad != 0) begin
            errors++;
            $display("FAIL pwm64_count: on=%0d bad=%0d expected on=128 bad=0", on_cnt, bad);
        end
        checks++;
        if (max_run != 64) begin
            errors++;
            $display("FAIL pwm64_run: run=%0d expected 64", max_run);
        end
        wr(3'd6, 32'd0, 4'hF);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (leds_export !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pwm0: %0d on cycles, expected 0", bad);
        end
        wr(3'd6, 32'd255, 4'hF);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (leds_export !== 8'hFF) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pwm255: %0d off cycles, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] ee;
        wr(3'd0, 32'h00, 4'hF);
        wr(3'd4, 32'h03, 4'hF);
        wr(3'd5, 32'h03, 4'hF);
        repeat (4) @(negedge clk);
        checks++;
        if (dut.phase_q !== 1'b1) begin
            errors++;
            $display("FAIL mid_phase_setup: phase=%b expected 1", dut.phase_q);
        end
        avs_address = 3'd7;
        avs_read    = 1'b1;
        rst         = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        avs_read = 1'b0;
        rst      = 1'b0;
        ee = exp_q.pop_front();
        checks++;
        if (avs_readdata !== ee) begin
            errors++;
            $display("FAIL mid_reset_rdata: readdata=%h expected %h", avs_readdata, ee);
        end
        chk_leds(8'hA5, "mid_reset_leds");
        rd(3'd7, 32'h0800_0000, 32'hFFFF_FF00, "mid_reset_status");
        rd(3'd5, 32'h0, 32'hFFFF_FFFF, "mid_reset_div");
        @(negedge clk);
        chk_leds(8'hA5, "mid_reset_leds_hold");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_atomic;
        test_byteenable;
        test_blink;
        test_back_to_back;
        test_pwm;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_pio_ctrl.md
Name: led_pio_ctrl

Overview:
- Parametrised Avalon-MM LED output peripheral; next generation of the fixed 8-bit `leds_export` PIO in the HPS system.
- Adds atomic set/clear/toggle writes, per-bit hardware blink with a programmable prescaler, and global 8-bit PWM brightness.
- Sits on the HPS lightweight bridge; `leds_export` drives the board LEDs directly.

Parameters:
- WIDTH, 8, number of output bits (1..32).
- DIV_W, 24, blink prescaler width in bits (1..32).
- RESET_VALUE, 0, reset value of the DATA register (WIDTH bits).

Ports:
- clk_clk  input  1  system clock; all logic on its rising edge.
- reset_reset  input  1  synchronous, active-high reset.
- avs_address  input  3  word address of the register.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_byteenable  input  4  byte lanes for writes.
- avs_readdata  output  32  read data, fixed read latency of 1.
- leds_export  output  WIDTH  registered LED outputs.

Behaviour:
- Register map (word address):
  - 0 DATA: rw.
  - 1 SET: wo, DATA |= wd.
  - 2 CLR: wo, DATA &= ~wd.
  - 3 TOG: wo, DATA ^= wd.
  - 4 BLINK_MASK: rw.
  - 5 BLINK_DIV: rw, DIV_W bits.
  - 6 PWM_DUTY: rw, 8 bits.
  - 7 STATUS: ro, [31:24]=WIDTH, [8]=blink_phase, [7:0]=pwm_cnt.
- Byteenable masking:
  - Only enabled byte lanes are written.
  - For SET/CLR/TOG, disabled lanes are treated as wd=0, so those bits are unchanged.
- Bits at or above WIDTH (or DIV_W, or 8 for PWM_DUTY) are ignored on write and read as 0. SET/CLR/TOG read as 0.
- No waitrequest. `avs_readdata` is registered and valid the cycle after `avs_read`; it holds its value otherwise.
- Read and write in the same cycle: the write is performed, and readdata returns the pre-write value.
- Writes to STATUS are ignored.
- Reset values:
  - DATA = RESET_VALUE; BLINK_MASK = 0; BLINK_DIV = 0; PWM_DUTY = 255.
  - Prescaler = 0; blink_phase = 0; pwm_cnt = 0.
  - avs_readdata = 0; leds_export = RESET_VALUE masked by the PWM term (1 at duty 255).
- Blink prescaler:
  - If BLINK_DIV == 0: prescaler held at 0 and blink_phase held at 0.
  - Otherwise the prescaler counts down. When it reaches 0 it reloads BLINK_DIV and toggles blink_phase, giving a half-period of BLINK_DIV+1 cycles.
  - A write to BLINK_DIV (any lane) loads the prescaler with the new value and clears blink_phase in the same cycle.
- PWM:
  - pwm_cnt counts 0..254 and wraps to 0 (period 255 cycles).
  - pwm_on = (pwm_cnt < PWM_DUTY). Duty 0 gives always off; duty 255 gives always on.
- Output: leds_export[i] <= (DATA[i] ^ (BLINK_MASK[i] & blink_phase)) & pwm_on, registered.
  - The output reflects a register write 1 cycle after the write cycle (visible at edge+2 relative to the write strobe edge).
- Reset mid-operation: all state returns to reset values on the next edge; a pending read returns 0.

Test Plan:
- Reset, WIDTH=8, RESET_VALUE=0xA5, idle bus → leds_export=0xA5 constantly; read addr 7 → 0x08000000 (pwm_cnt bits vary).
- Write DATA=0x0F; SET 0x30; CLR 0x01; TOG 0xFF → DATA readback 0x0F, 0x3F, 0x3E, 0xC1; leds_export tracks each 2 edges after the write strobe; read addr 1 → 0.
- Write DATA=0x12345678 with byteenable=4'b0001 → DATA=0x78; SET 0x0000FF00 with byteenable=0 → DATA unchanged.
- BLINK_MASK=0x03, BLINK_DIV=3, DATA=0x00 → leds_export[1:0] alternates 00/11 every 4 cycles; rewrite BLINK_DIV=0 → bits return to 00 and stay.
- PWM_DUTY=64, DATA=0xFF → leds_export=0xFF for exactly 64 of every 255 cycles; duty 0 → always 0; duty 255 → always 0xFF.
- Assert reset during blink at phase=1 with pending read → next cycle leds_export=RESET_VALUE, readdata=0, STATUS[8]=0.
